// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between the CPU M stage and a debug/loader port
// The CPU owns the memory by default; a starved DBG port is given a bounded forced window.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int DBG_QUOTA    = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wd,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [0:0] CPU_PRI   = 1'b0;
  localparam logic [0:0] DBG_FORCE = 1'b1;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int QW = $clog2(DBG_QUOTA + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [QW-1:0] QUOTA_LAST  = QW'(DBG_QUOTA - 1);

  logic [0:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [QW-1:0] quota_cnt;
  logic          gnt_cpu;

  assign cpu_rd = mem_rd;

  // Grants are suppressed during reset so nothing reaches memory in a reset cycle.
  always_comb begin
    gnt_cpu = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (state == CPU_PRI) begin
        gnt_cpu = cpu_req;
        dbg_gnt = dbg_req & ~cpu_req;
      end else begin
        dbg_gnt = dbg_req;
        gnt_cpu = cpu_req & ~dbg_req;
      end
    end
    cpu_stall = cpu_req & ~gnt_cpu & ~reset;
    mem_we    = (gnt_cpu & cpu_we) | (dbg_gnt & dbg_we);
    mem_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    mem_wd    = dbg_gnt ? dbg_wd : cpu_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CPU_PRI;
      starve_cnt  <= '0;
      quota_cnt   <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= '0;
      stall_count <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rd;
      end
      if (cpu_stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
        stall_count <= stall_count + CNT_WIDTH'(1);
      end

      if (state == CPU_PRI) begin
        if (!dbg_req || dbg_gnt) begin
          starve_cnt <= '0;
        end else if (cpu_req) begin
          if (starve_cnt == STARVE_LAST) begin
            state      <= DBG_FORCE;
            starve_cnt <= '0;
            quota_cnt  <= '0;
          end else begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
      end else begin
        // The window closes early if DBG goes idle, so a stale window cannot stall the CPU.
        if (!dbg_req || (dbg_gnt && (quota_cnt == QUOTA_LAST))) begin
          state      <= CPU_PRI;
          starve_cnt <= '0;
          quota_cnt  <= '0;
        end else if (dbg_gnt) begin
          quota_cnt <= quota_cnt + QW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wd, dbg_wd;
  logic [31:0] cpu_rd, dbg_rdata, mem_wd, mem_rd;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] stall_count;

  logic [31:0] n_cpu_rd, n_dbg_rdata, n_mem_wd;
  logic        n_cpu_stall, n_dbg_gnt, n_dbg_rvalid, n_mem_we;
  logic [7:0]  n_mem_addr;
  logic [3:0]  n_stall_count;

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stall_count(stall_count)
  );

  dmem_arbiter #(.CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(n_cpu_rd), .cpu_stall(n_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_gnt(n_dbg_gnt), .dbg_rvalid(n_dbg_rvalid), .dbg_rdata(n_dbg_rdata),
    .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wd(n_mem_wd), .mem_rd(mem_rd),
    .stall_count(n_stall_count)
  );

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wd;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wd;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_gnt;
    logic        e_stall;
    logic [31:0] e_rd;
    logic        e_rvalid;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wd = 32'h0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 8'h00; dbg_wd = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1;
    idle();
    #1;

    // scenario 1: reset blocks grants and writes even with both ports requesting
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wd = 32'h11;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h06; dbg_wd = 32'h22;
    @(negedge clk);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_stall_count", {16'b0, stall_count}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("rst_mem05", mem[8'h05], 32'd0);
    chk("rst_mem06", mem[8'h06], 32'd0);
    next_cycle();

    // single-cycle vectors, never more than two contention rows in a row
    tbl[0] = '{0,0,8'h11,32'h0000000A, 0,0,8'h22,32'h0000000B, 0,8'h11,32'h0000000A, 0,0,32'h0,        0};
    tbl[1] = '{1,1,8'h20,32'h00001234, 0,0,8'h22,32'h0000000B, 1,8'h20,32'h00001234, 0,0,32'h0,        0};
    tbl[2] = '{1,0,8'h20,32'h00000005, 0,0,8'h22,32'h0000000B, 0,8'h20,32'h00000005, 0,0,32'h00001234, 0};
    tbl[3] = '{0,1,8'h30,32'h00000077, 1,1,8'h40,32'h0000CAFE, 1,8'h40,32'h0000CAFE, 1,0,32'h0,        0};
    tbl[4] = '{1,1,8'h50,32'h00001111, 1,1,8'h50,32'h00002222, 1,8'h50,32'h00001111, 0,0,32'h0,        0};
    tbl[5] = '{1,0,8'h60,32'h00000003, 1,1,8'h61,32'h00000004, 0,8'h60,32'h00000003, 0,0,32'h0,        0};
    tbl[6] = '{0,1,8'h70,32'h00000009, 1,0,8'h20,32'h00000000, 0,8'h20,32'h00000000, 1,0,32'h00001234, 0};
    tbl[7] = '{1,1,8'h71,32'h00000055, 1,0,8'h72,32'h00000000, 1,8'h71,32'h00000055, 0,0,32'h0,        1};

    for (int i = 0; i < 8; i++) begin
      cpu_req = tbl[i].cpu_req; cpu_we = tbl[i].cpu_we;
      cpu_addr = tbl[i].cpu_addr; cpu_wd = tbl[i].cpu_wd;
      dbg_req = tbl[i].dbg_req; dbg_we = tbl[i].dbg_we;
      dbg_addr = tbl[i].dbg_addr; dbg_wd = tbl[i].dbg_wd;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      chk($sformatf("vec%0d_mem_addr", i), {24'b0, mem_addr}, {24'b0, tbl[i].e_addr});
      chk($sformatf("vec%0d_mem_wd", i), mem_wd, tbl[i].e_wd);
      chk($sformatf("vec%0d_dbg_gnt", i), {31'b0, dbg_gnt}, {31'b0, tbl[i].e_gnt});
      chk($sformatf("vec%0d_cpu_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("vec%0d_cpu_rd", i), cpu_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d_dbg_rvalid", i), {31'b0, dbg_rvalid}, {31'b0, tbl[i].e_rvalid});
      next_cycle();
    end
    idle();
    chk("mem20", mem[8'h20], 32'h00001234);
    chk("mem40", mem[8'h40], 32'h0000CAFE);
    chk("mem50_cpu_wins", mem[8'h50], 32'h00001111);
    chk("mem61_dbg_lost", mem[8'h61], 32'h0);
    chk("mem71", mem[8'h71], 32'h00000055);

    // scenario 2: DBG-only read, registered data one cycle later
    do_reset();
    mem[8'h10] = 32'hDEADBEEF;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    @(negedge clk);
    chk("s2_c0_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("s2_c0_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    next_cycle();
    dbg_req = 0;
    @(negedge clk);
    chk("s2_c1_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("s2_c1_rdata", dbg_rdata, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    chk("s2_c2_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    chk("s2_c2_rdata_hold", dbg_rdata, 32'hDEADBEEF);
    next_cycle();

    // scenario 3: sustained contention forces a two-grant DBG window after four lost cycles
    do_reset();
    cpu_req = 1; cpu_addr = 8'h01; dbg_req = 1; dbg_addr = 8'h02;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("s3_c%0d_gnt", c), {31'b0, dbg_gnt}, {31'b0, (c == 4 || c == 5)});
      chk($sformatf("s3_c%0d_stall", c), {31'b0, cpu_stall}, {31'b0, (c == 4 || c == 5)});
      if (c == 5) chk("s3_c5_rvalid", {31'b0, dbg_rvalid}, 32'd1);
      if (c == 6) chk("s3_stall_count", {16'b0, stall_count}, 32'd2);
      next_cycle();
    end

    // scenario 4: DBG goes idle after the first forced grant
    do_reset();
    cpu_req = 1; dbg_req = 1;
    for (int c = 0; c <= 10; c++) begin
      dbg_req = (c != 5);
      @(negedge clk);
      if (c >= 4) begin
        chk($sformatf("s4_c%0d_gnt", c), {31'b0, dbg_gnt}, {31'b0, (c == 4 || c == 10)});
        chk($sformatf("s4_c%0d_stall", c), {31'b0, cpu_stall}, {31'b0, (c == 4 || c == 10)});
      end
      next_cycle();
    end

    // scenario 5: reset in the cycle DBG would be forced, with writes presented on both ports
    do_reset();
    cpu_req = 1; dbg_req = 1;
    for (int c = 0; c <= 9; c++) begin
      reset = (c == 4);
      cpu_we = (c == 4); cpu_addr = (c == 4) ? 8'h90 : 8'h01; cpu_wd = 32'h00000BAD;
      dbg_we = (c == 4); dbg_addr = (c == 4) ? 8'h91 : 8'h02; dbg_wd = 32'h0000BAD2;
      @(negedge clk);
      if (c == 4) chk("s5_rst_mem_we", {31'b0, mem_we}, 32'd0);
      if (c == 5) chk("s5_c5_rvalid", {31'b0, dbg_rvalid}, 32'd0);
      if (c >= 4) begin
        chk($sformatf("s5_c%0d_gnt", c), {31'b0, dbg_gnt}, {31'b0, (c == 9)});
        chk($sformatf("s5_c%0d_stall", c), {31'b0, cpu_stall}, {31'b0, (c == 9)});
      end
      next_cycle();
    end
    reset = 1'b0;
    idle();
    chk("s5_mem90", mem[8'h90], 32'h0);
    chk("s5_mem91", mem[8'h91], 32'h0);

    // scenario 6: 60 contention cycles give 20 stalls; the 4-bit counter pins at 0xF
    do_reset();
    cpu_req = 1; dbg_req = 1;
    for (int c = 0; c < 60; c++) next_cycle();
    @(negedge clk);
    chk("s6_wide_count", {16'b0, stall_count}, 32'd20);
    chk("s6_narrow_sat", {28'b0, n_stall_count}, 32'h0000000F);
    idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
